// File: rtl/fnd_scan_controller.sv
// Multi-digit seven-segment scan controller.
// Walks a one-hot digit select across NUM_DIGITS commons. Each digit is held
// for DIV cycles and opens with BLANK_CYCLES of dead-time to avoid ghosting.
// It also applies per-digit masking and leading-zero suppression.
// All outputs are registered and computed from next-state counters, so they
// move on the same edge as the position index.
module fnd_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int POS_W        = $clog2(NUM_DIGITS),
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dots,
  input  logic [NUM_DIGITS-1:0]   i_digit_mask,
  input  logic                    i_lz_en,
  output logic [NUM_DIGITS-1:0]   o_digit,
  output logic [POS_W-1:0]        o_digit_pos,
  output logic [3:0]              o_bcd,
  output logic                    o_dp,
  output logic                    o_scan_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_DIGITS - 1);
  localparam logic POL = ACTIVE_LOW;

  logic [CNT_W-1:0]      prescaler_q, prescaler_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  dp_q, dp_d;
  logic                  tick_q, tick_d;

  logic [NUM_DIGITS-1:0] lzDark;
  logic [NUM_DIGITS-1:0] posSel;
  logic                  dotReq;
  logic                  digitDark;
  logic                  blankDone;
  logic                  lit;

  // Advance the prescaler and step the position at the end of each slot.
  always_comb begin
    prescaler_d = '0;
    pos_d       = '0;
    tick_d      = 1'b0;
    if (i_enable) begin
      if (prescaler_q == LAST_CNT) begin
        prescaler_d = '0;
        tick_d      = 1'b1;
        pos_d       = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
      end else begin
        prescaler_d = prescaler_q + CNT_W'(1);
        pos_d       = pos_q;
      end
    end
  end

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic allZero;
    allZero = 1'b1;
    lzDark  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      allZero   = allZero & (i_data[4*k +: 4] == 4'h0);
      lzDark[k] = i_lz_en & allZero & (k != 0);
    end
  end

  // The dead-time window covers the first BLANK_CYCLES counts of each slot.
  generate
    if (BLANK_CYCLES == 0) begin : g_noBlank
      assign blankDone = 1'b1;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);
      assign blankDone = (prescaler_d >= BLANK_CNT);
    end
  endgenerate

  // Select the nibble, dot and darkening state of the digit about to be shown.
  always_comb begin
    bcd_d     = '0;
    posSel    = '0;
    dotReq    = 1'b0;
    digitDark = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (pos_d == POS_W'(k)) begin
        bcd_d     = i_data[4*k +: 4];
        posSel[k] = 1'b1;
        dotReq    = i_dots[k];
        digitDark = ~i_digit_mask[k] | lzDark[k];
      end
    end
    lit     = i_enable & blankDone & ~digitDark;
    digit_d = (lit ? posSel : '0) ^ {NUM_DIGITS{POL}};
    dp_d    = (lit & dotReq) ^ POL;
  end

  // State and output registers; reset leaves every digit dark at position 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prescaler_q <= '0;
      pos_q       <= '0;
      digit_q     <= {NUM_DIGITS{POL}};
      bcd_q       <= '0;
      dp_q        <= POL;
      tick_q      <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      pos_q       <= pos_d;
      digit_q     <= digit_d;
      bcd_q       <= bcd_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
    end
  end

  assign o_digit     = digit_q;
  assign o_digit_pos = pos_q;
  assign o_bcd       = bcd_q;
  assign o_dp        = dp_q;
  assign o_scan_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller.
// Two instances run here: a 4-digit active-low one with dead-time, and an
// 8-digit active-high one without. Stimulus queues hand-computed per-cycle
// expectations, and a negedge monitor pops and compares them.
module tb_fnd_scan_controller;

  logic clk = 1'b0;
  logic rstN;

  logic        enA, lzA;
  logic [15:0] dataA;
  logic [3:0]  dotsA, maskA;
  logic [3:0]  digitA, bcdA;
  logic [1:0]  posA;
  logic        dpA, tickA;

  logic        enB, lzB;
  logic [31:0] dataB;
  logic [7:0]  dotsB, maskB;
  logic [7:0]  digitB;
  logic [3:0]  bcdB;
  logic [2:0]  posB;
  logic        dpB, tickB;

  typedef struct packed {
    logic [7:0] digit;
    logic [2:0] pos;
    logic [3:0] bcd;
    logic       dp;
    logic       tick;
  } obs_t;

  obs_t qA[$];
  obs_t qB[$];
  int compared   = 0;
  int mismatched = 0;

  // Free-running 100 MHz clock shared by both instances.
  always #5 clk = ~clk;

  fnd_scan_controller #(
    .NUM_DIGITS(4), .DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b1)
  ) dutA (
    .i_clk(clk), .i_reset_n(rstN), .i_enable(enA), .i_data(dataA),
    .i_dots(dotsA), .i_digit_mask(maskA), .i_lz_en(lzA),
    .o_digit(digitA), .o_digit_pos(posA), .o_bcd(bcdA), .o_dp(dpA),
    .o_scan_tick(tickA)
  );

  fnd_scan_controller #(
    .NUM_DIGITS(8), .DIV(3), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)
  ) dutB (
    .i_clk(clk), .i_reset_n(rstN), .i_enable(enB), .i_data(dataB),
    .i_dots(dotsB), .i_digit_mask(maskB), .i_lz_en(lzB),
    .o_digit(digitB), .o_digit_pos(posB), .o_bcd(bcdB), .o_dp(dpB),
    .o_scan_tick(tickB)
  );

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got digit=%h pos=%0d bcd=%h dp=%b tick=%b, expected digit=%h pos=%0d bcd=%h dp=%b tick=%b",
               name, $time, act.digit, act.pos, act.bcd, act.dp, act.tick,
               exp.digit, exp.pos, exp.bcd, exp.dp, exp.tick);
    end
  endtask

  // Monitor: each queued expectation is matched against the outputs at the next falling edge.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (qA.size() > 0) begin
      e = qA.pop_front();
      a = {4'b0, digitA, 1'b0, posA, bcdA, dpA, tickA};
      checkOutput("dutA", a, e);
    end
    if (qB.size() > 0) begin
      e = qB.pop_front();
      a = {digitB, posB, bcdB, dpB, tickB};
      checkOutput("dutB", a, e);
    end
  end

  function automatic obs_t mkA(input logic [3:0] d, input logic [1:0] p,
                               input logic [3:0] b, input logic dp, input logic t);
    return {4'b0, d, 1'b0, p, b, dp, t};
  endfunction

  function automatic obs_t mkB(input logic [7:0] d, input logic [2:0] p,
                               input logic [3:0] b, input logic dp, input logic t);
    return {d, p, b, dp, t};
  endfunction

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dots,
                               input logic [3:0] mask, input logic lz);
    dataA = d;
    dotsA = dots;
    maskA = mask;
    lzA   = lz;
  endtask

  task automatic step(input bit doA, input obs_t eA, input bit doB, input obs_t eB);
    @(posedge clk);
    #1;
    if (doA) qA.push_back(eA);
    if (doB) qB.push_back(eB);
  endtask

  task automatic stepA(input logic [3:0] d, input logic [1:0] p, input logic [3:0] b,
                       input logic dp, input logic t);
    step(1'b1, mkA(d, p, b, dp, t), 1'b0, '0);
  endtask

  task automatic stepB(input logic [7:0] d, input logic [2:0] p, input logic [3:0] b,
                       input logic dp, input logic t);
    step(1'b0, '0, 1'b1, mkB(d, p, b, dp, t));
  endtask

  task automatic slotA(input logic [1:0] p, input logic [3:0] litDigit,
                       input logic [3:0] b, input logic litDp);
    stepA(4'hF, p, b, 1'b1, 1'b1);
    repeat (3) stepA(litDigit, p, b, litDp, 1'b0);
  endtask

  task automatic slotB(input logic [2:0] p, input logic [7:0] d,
                       input logic [3:0] b, input logic dp);
    stepB(d, p, b, dp, 1'b1);
    repeat (2) stepB(d, p, b, dp, 1'b0);
  endtask

  // Watchdog so the run always ends with a summary.
  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Directed scenario sequence.
  initial begin
    rstN = 1'b0;
    enA  = 1'b0;
    enB  = 1'b0;
    applyStimulus(16'h1234, 4'b0000, 4'b1111, 1'b0);
    dataB = 32'h87654321;
    dotsB = 8'h04;
    maskB = 8'hFF;
    lzB   = 1'b0;

    $display("[TB] reset state");
    step(1'b1, mkA(4'hF, 0, 4'h0, 1'b1, 1'b0), 1'b1, mkB(8'h00, 0, 4'h0, 1'b0, 1'b0));
    step(1'b1, mkA(4'hF, 0, 4'h0, 1'b1, 1'b0), 1'b1, mkB(8'h00, 0, 4'h0, 1'b0, 1'b0));
    rstN = 1'b1;
    step(1'b1, mkA(4'hF, 0, 4'h4, 1'b1, 1'b0), 1'b1, mkB(8'h00, 0, 4'h1, 1'b0, 1'b0));

    $display("[TB] basic scan 1234");
    enA = 1'b1;
    repeat (3) stepA(4'hE, 0, 4'h4, 1'b1, 1'b0);
    slotA(1, 4'hD, 4'h3, 1'b1);
    slotA(2, 4'hB, 4'h2, 1'b1);
    slotA(3, 4'h7, 4'h1, 1'b1);
    slotA(0, 4'hE, 4'h4, 1'b1);

    $display("[TB] leading-zero suppression");
    applyStimulus(16'h0050, 4'b0000, 4'b1111, 1'b1);
    slotA(1, 4'hD, 4'h5, 1'b1);
    slotA(2, 4'hF, 4'h0, 1'b1);
    slotA(3, 4'hF, 4'h0, 1'b1);
    slotA(0, 4'hE, 4'h0, 1'b1);
    applyStimulus(16'h0000, 4'b0000, 4'b1111, 1'b1);
    slotA(1, 4'hF, 4'h0, 1'b1);
    slotA(2, 4'hF, 4'h0, 1'b1);
    slotA(3, 4'hF, 4'h0, 1'b1);
    slotA(0, 4'hE, 4'h0, 1'b1);

    $display("[TB] masking and dots");
    applyStimulus(16'h1234, 4'b0001, 4'b1010, 1'b0);
    slotA(1, 4'hD, 4'h3, 1'b1);
    slotA(2, 4'hF, 4'h2, 1'b1);
    slotA(3, 4'h7, 4'h1, 1'b1);
    slotA(0, 4'hF, 4'h4, 1'b1);
    applyStimulus(16'h1234, 4'b0101, 4'b1111, 1'b0);
    slotA(1, 4'hD, 4'h3, 1'b1);
    slotA(2, 4'hB, 4'h2, 1'b0);
    slotA(3, 4'h7, 4'h1, 1'b1);
    slotA(0, 4'hE, 4'h4, 1'b0);

    $display("[TB] asynchronous reset mid-slot");
    slotA(1, 4'hD, 4'h3, 1'b1);
    stepA(4'hF, 2, 4'h2, 1'b1, 1'b1);
    stepA(4'hB, 2, 4'h2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    qA.push_back(mkA(4'hF, 0, 4'h0, 1'b1, 1'b0));
    stepA(4'hF, 0, 4'h0, 1'b1, 1'b0);
    rstN = 1'b1;
    repeat (3) stepA(4'hE, 0, 4'h4, 1'b0, 1'b0);
    slotA(1, 4'hD, 4'h3, 1'b1);

    $display("[TB] enable drop");
    slotA(2, 4'hB, 4'h2, 1'b0);
    stepA(4'hF, 3, 4'h1, 1'b1, 1'b1);
    stepA(4'h7, 3, 4'h1, 1'b1, 1'b0);
    enA = 1'b0;
    repeat (5) stepA(4'hF, 0, 4'h4, 1'b1, 1'b0);
    enA = 1'b1;
    repeat (3) stepA(4'hE, 0, 4'h4, 1'b0, 1'b0);
    slotA(1, 4'hD, 4'h3, 1'b1);
    enA = 1'b0;
    stepA(4'hF, 0, 4'h4, 1'b1, 1'b0);

    $display("[TB] 8-digit active-high scan");
    stepB(8'h00, 0, 4'h1, 1'b0, 1'b0);
    enB = 1'b1;
    repeat (2) stepB(8'h01, 0, 4'h1, 1'b0, 1'b0);
    slotB(1, 8'h02, 4'h2, 1'b0);
    slotB(2, 8'h04, 4'h3, 1'b1);
    slotB(3, 8'h08, 4'h4, 1'b0);
    slotB(4, 8'h10, 4'h5, 1'b0);
    slotB(5, 8'h20, 4'h6, 1'b0);
    slotB(6, 8'h40, 4'h7, 1'b0);
    slotB(7, 8'h80, 4'h8, 1'b0);
    slotB(0, 8'h01, 4'h1, 1'b0);

    @(negedge clk);
    #1;
    compared++;
    if (qA.size() != 0 || qB.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", qA.size(), qB.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Parametrised multi-digit seven-segment scan controller. It generalises the fixed 2-to-4 digit-select decoder into a self-timed scanner with:
- any digit count
- a programmable refresh divider
- a ghosting dead-time
- per-digit blanking
- leading-zero suppression
- selectable select polarity

It sits between the counter/BCD datapath and the BCD-to-segment decoder, driving the board's digit-common lines directly.

Parameters:
NUM_DIGITS, 4, number of scanned digits; legal range is at least 2.
POS_W, $clog2(NUM_DIGITS), width of the position index; derived, not overridden.
DIV, 100000, clock cycles each digit is held; legal range is at least 2 (1 kHz per digit at 100 MHz).
BLANK_CYCLES, 1000, dead-time cycles at the start of each digit slot with all selects inactive; legal range is 0 to DIV-1.
ACTIVE_LOW, 1, 1 = digit-select and decimal-point outputs are active-low; 0 = active-high.

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous, active-low reset
i_enable  input  1  scan enable; 0 holds the scanner idle with all digits off
i_data  input  4*NUM_DIGITS  BCD nibbles; digit k is bits [4k+3:4k], digit 0 is rightmost
i_dots  input  NUM_DIGITS  decimal-point request per digit, 1 = lit
i_digit_mask  input  NUM_DIGITS  per-digit enable, 0 = digit forced dark
i_lz_en  input  1  leading-zero suppression enable
o_digit  output  NUM_DIGITS  one-hot digit select, polarity per ACTIVE_LOW
o_digit_pos  output  POS_W  index of the digit currently scanned
o_bcd  output  4  nibble for the current digit, to the segment decoder
o_dp  output  1  decimal point for the current digit, polarity per ACTIVE_LOW
o_scan_tick  output  1  one-cycle pulse on each digit advance

Behaviour:
State:
- Prescaler counts 0..DIV-1.
- Position register counts 0..NUM_DIGITS-1.
- All outputs are registered.

Reset (i_reset_n low, asynchronous):
- Prescaler = 0, position = 0.
- o_digit = all inactive (all 1s when ACTIVE_LOW=1, all 0s otherwise).
- o_digit_pos = 0, o_bcd = 0, o_dp = inactive, o_scan_tick = 0.
- Reset mid-scan aborts immediately. After release the scan restarts at position 0 with a full blank window.

Idle (i_enable = 0):
- Prescaler and position are synchronously forced to 0.
- o_digit and o_dp are inactive; o_scan_tick = 0.
- o_bcd continues to track the digit-0 nibble.

Scan (i_enable = 1):
- Prescaler increments every cycle.
- On the edge where prescaler = DIV-1:
  - prescaler <= 0
  - position <= position+1, wrapping NUM_DIGITS-1 -> 0
  - o_scan_tick <= 1 for exactly one cycle
- Each digit slot is therefore exactly DIV cycles, and a full frame is NUM_DIGITS*DIV cycles.
- o_digit_pos always equals the position register.

Output computation:
- o_digit, o_bcd and o_dp are computed from the next-state prescaler and position. They therefore change on the same edge as o_digit_pos.
- Data inputs reach the outputs with 1 cycle of latency.
- o_bcd = i_data nibble at the current position. It is valid even while the digit is dark.

Digit darkening rules:
- Blank: while prescaler < BLANK_CYCLES, o_digit and o_dp are inactive. With BLANK_CYCLES = 0 there is no dead-time.
- Mask: if i_digit_mask[pos] = 0, the digit stays dark for its whole slot. The slot is still consumed, so duty cycle is unchanged and masked digits are not skipped.
- Leading-zero suppression: digit k (k >= 1) is dark when i_lz_en = 1 and every nibble k..NUM_DIGITS-1 equals 0. Digit 0 is never suppressed, so the value 0 shows a single "0".
- A suppressed digit also suppresses its decimal point.

Lit digit:
- o_digit = one-hot of position (the inverted one-hot when ACTIVE_LOW=1).
- o_dp = i_dots[pos], applying the polarity.

Other rules:
- Simultaneous input changes in mid-slot take effect on the next cycle. No glitch-free guarantee is required beyond registered outputs.
- Nibbles above 9 are passed through unaltered, with no BCD checking.

Test Plan:
1. DIV=4, BLANK_CYCLES=1, NUM_DIGITS=4, ACTIVE_LOW=1; i_data=16'h1234, all masks 1, i_lz_en=0, enable after reset release -> each slot is 1 cycle o_digit=4'b1111 then 3 cycles active; pos0 gives 4'b1110 with o_bcd=4, pos1 gives 4'b1101 with o_bcd=3, pos2 gives 4'b1011 with o_bcd=2, pos3 gives 4'b0111 with o_bcd=1, then wrap to pos0. o_scan_tick pulses every 4 cycles.
2. Same setup, i_data=16'h0050, i_lz_en=1 -> digits 3 and 2 stay 4'b1111 for their whole slots; digit 1 lit with o_bcd=5; digit 0 lit with o_bcd=0. With i_data=16'h0000, only digit 0 is lit.
3. i_digit_mask=4'b1010, i_dots=4'b0001 -> digits 0 and 2 are dark and their o_dp is inactive (1); digits 1 and 3 are lit with o_dp=1 (unlit); frame length remains 16 cycles.
4. Assert i_reset_n=0 mid-slot at pos2 -> on the same edge o_digit=4'b1111, o_digit_pos=0, o_dp=1; after release the first active select is 4'b1110 after the blank cycle.
5. Drop i_enable at pos3 for 5 cycles, then raise it -> all digits dark and no ticks while low; the scan resumes at pos0 with the prescaler counting from 0.
6. ACTIVE_LOW=0, NUM_DIGITS=8, BLANK_CYCLES=0, i_data=32'h87654321 -> o_digit walks 8'h01..8'h80 with o_bcd 1..8, and there are no dark cycles.
